// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
package uart_pkg;
  localparam int UART_CLKS_PER_BIT = 10416;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a previous-value flop for fall detection.
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic rx_s,
  output logic fall_o
);
  logic meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;

  always_comb begin
    meta_d = rx_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Line idles high, so reset to 1 to avoid a false fall on release.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s   = sync_q;
  assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity_err_o pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       busy_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       frame_err_o
);
  localparam logic [13:0] HALF_LD = 14'(CLKS_PER_BIT / 2 - 1);
  localparam logic [13:0] FULL_LD = 14'(CLKS_PER_BIT - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .rx_i   (rx_i),
    .rx_s   (rx_s),
    .fall_o (fall)
  );

  uart_rx_state_e state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d, byte_q, byte_d;
  logic        valid_q, valid_d, busy_q, busy_d, ferr_q, ferr_d;
  logic        tick;
`ifdef UART_RX_PARITY_EN
  logic        par_ph_q, par_ph_d, par_bit_q, par_bit_d, perr_q, perr_d;
`endif

  assign tick = (cnt_q == 14'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;
`ifdef UART_RX_PARITY_EN
    par_ph_d  = par_ph_q;
    par_bit_d = par_bit_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = HALF_LD;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (!tick) cnt_d = cnt_q - 14'd1;
        else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = FULL_LD;
          idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
          cnt_d   = HALF_LD;
          busy_d  = 1'b0;
        end
      end
      DATA: begin
        if (!tick) cnt_d = cnt_q - 14'd1;
        else begin
          cnt_d = FULL_LD;
`ifdef UART_RX_PARITY_EN
          // Parity rides in DATA as a ninth sample so the enum stays 2-bit.
          if (par_ph_q) begin
            par_bit_d = rx_s;
            par_ph_d  = 1'b0;
            state_d   = STOP;
          end else begin
            shift_d = {rx_s, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) par_ph_d = 1'b1;
          end
`else
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
      STOP: begin
        if (!tick) cnt_d = cnt_q - 14'd1;
        else begin
          state_d = IDLE;
          cnt_d   = HALF_LD;
          busy_d  = 1'b0;
          if (!rx_s) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (^{shift_q, par_bit_q}) perr_d = 1'b1;
`endif
          else begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = HALF_LD;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= HALF_LD;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ph_q  <= 1'b0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_ph_q  <= par_ph_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign byte_o      = byte_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=16: frame table plus hand sequences, scoreboard on output pulses.
module tb_uart_rx;
  localparam int C = 16;
  localparam int K_VALID = 0, K_FERR = 1, K_PERR = 2;

  logic clk_i = 1'b0, reset_i, rx_i;
  logic [7:0] byte_o;
  logic valid_o, busy_o, frame_err_o;
`ifdef UART_RX_PARITY_EN
  logic parity_err_o;
  logic par_flip = 1'b0;
`endif

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rx_i       (rx_i),
    .byte_o     (byte_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int kind; logic [7:0] b;} exp_t;
  typedef struct {logic [7:0] data; logic stop_v; int gap; int kind; logic [7:0] exp_b;} vec_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int cyc = 0, last_pulse_cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (C) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ par_flip);
`endif
    drive_bit(stop_v);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] b);
    exp_t e;
    e.kind = kind;
    e.b    = b;
    sb.push_back(e);
    if (kind == K_VALID) last_good = b;
  endtask

  // Any output pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    logic pe;
    exp_t e;
    pe = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe = parity_err_o;
`endif
    if (!reset_i && (valid_o || frame_err_o || pe)) begin
      last_pulse_cyc = cyc;
      chk("pulse_exclusive", {30'd0, valid_o, frame_err_o} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
      chk("busy_at_pulse", {31'd0, busy_o}, 32'd0);
      if (sb.size() == 0) chk("unexpected_pulse", {29'd0, pe, frame_err_o, valid_o}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("pulse_kind", valid_o ? K_VALID : (frame_err_o ? K_FERR : K_PERR), e.kind);
        chk("byte_o", {24'd0, byte_o}, {24'd0, e.b});
      end
    end
  end

  vec_t tbl[6];

  initial begin
    int t0;
    tbl[0] = '{8'h00, 1'b1, 0,  K_VALID, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 0,  K_VALID, 8'hFF};
    tbl[2] = '{8'h3C, 1'b0, 20, K_FERR,  8'hFF};
    tbl[3] = '{8'h55, 1'b1, 5,  K_VALID, 8'h55};
    tbl[4] = '{8'h81, 1'b0, 12, K_FERR,  8'h55};
    tbl[5] = '{8'hC3, 1'b1, 3,  K_VALID, 8'hC3};

    rx_i = 1'b1;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_byte", {24'd0, byte_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    reset_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;

    // 0xA5: latency from line fall to valid_o, busy held mid-frame
    t0 = cyc;
    expect_ev(K_VALID, 8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (4) @(negedge clk_i);
        chk("busy_early", {31'd0, busy_o}, 32'd1);
        repeat (140) @(negedge clk_i);
        chk("busy_late", {31'd0, busy_o}, 32'd1);
      end
    join
    chk("a5_latency", last_pulse_cyc - t0, 32'd155);
    repeat (4) @(posedge clk_i);
    #1;

    // Table: back-to-back frames when gap is 0, stop-bit errors otherwise
    for (int i = 0; i < 6; i++) begin
      chk("tbl_exp_byte", {24'd0, (tbl[i].kind == K_VALID) ? tbl[i].data : last_good}, {24'd0, tbl[i].exp_b});
      expect_ev(tbl[i].kind, tbl[i].exp_b);
      send_frame(tbl[i].data, tbl[i].stop_v);
      rx_i = 1'b1;
      repeat (tbl[i].gap) @(posedge clk_i);
      #1;
    end
    repeat (10) @(posedge clk_i);
    #1;

    // Start-bit glitch: 4 cycles low, rejected with no pulse
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    @(negedge clk_i);
    chk("glitch_busy_hi", {31'd0, busy_o}, 32'd1);
    repeat (15) @(negedge clk_i);
    chk("glitch_busy_lo", {31'd0, busy_o}, 32'd0);
    repeat (10) @(posedge clk_i);
    #1;

    // Bad stop, then line held low: no new frame until high then low again
    expect_ev(K_FERR, last_good);
    send_frame(8'h3C, 1'b0);
    repeat (60) @(posedge clk_i);
    #1;
    chk("held_low_busy", {31'd0, busy_o}, 32'd0);
    rx_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    expect_ev(K_VALID, 8'h42);
    send_frame(8'h42, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;

    // Reset mid data bit 4 of 0x5A, then 0x81 received cleanly
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(((i == 1) || (i == 3)) ? 1'b1 : 1'b0);
    rx_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_byte", {24'd0, byte_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err_o}, 32'd0);
    last_good = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
    expect_ev(K_VALID, 8'h81);
    send_frame(8'h81, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    expect_ev(K_VALID, 8'h07);
    send_frame(8'h07, 1'b1);
    rx_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    par_flip = 1'b1;
    expect_ev(K_PERR, 8'h07);
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
`endif

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk_i);
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clk_i cycles per bit (9600 baud at 100 MHz); legal range 8..16383.
REQ-002 SHALL have port clk_i  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_i  input  1  serial line, asynchronous to clk_i, idles high.
REQ-005 SHALL have port byte_o  output  8  last correctly received byte.
REQ-006 SHALL have port valid_o  output  1  one-cycle pulse: byte_o updated this cycle.
REQ-007 SHALL have port busy_o  output  1  high while a frame is being received.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-009 SHALL pass rx_i through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-010 SHALL use FSM states IDLE, START, DATA, STOP; one 14-bit down-counter for bit timing; one 3-bit data-bit index.
REQ-011 IDLE: on a falling edge of rx_s (previous 1, current 0) SHALL go to START, load counter with CLKS_PER_BIT/2 - 1 (integer division), and set busy_o the next cycle.
REQ-012 IDLE SHALL ignore a line held low; only a 1->0 transition starts a frame.
REQ-013 START: at counter == 0 (mid start bit) SHALL sample rx_s; low -> DATA, counter reloaded with CLKS_PER_BIT - 1; high -> glitch, back to IDLE, no output pulse.
REQ-014 DATA: at each counter == 0 SHALL shift rx_s into the shift register LSB first, reload counter with CLKS_PER_BIT - 1; after the 8th sample go to STOP.
REQ-015 STOP: at counter == 0 SHALL sample rx_s; high -> byte_o loaded and valid_o pulsed for exactly one cycle; low -> frame_err_o pulsed for one cycle, byte_o unchanged; both cases return to IDLE.
REQ-016 Sample points SHALL be edge-detect cycle + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, k = 0 (start), 1..8 (data), 9 (stop); valid_o/frame_err_o SHALL assert the cycle after the stop sample.
REQ-017 busy_o SHALL deassert in the same cycle valid_o or frame_err_o asserts, or the cycle after a START glitch rejection.
REQ-018 valid_o and frame_err_o SHALL never assert in the same cycle.
REQ-019 Back-to-back frames: a start edge arriving one cycle after returning to IDLE SHALL be accepted with no lost byte.
REQ-020 rx_i activity during START/DATA/STOP other than at sample points SHALL be ignored.

Reset
REQ-021 On reset_i high, immediately and regardless of state: FSM = IDLE, counter = CLKS_PER_BIT/2 - 1, bit index = 0, shift register = 0, synchronizer flops = 1, byte_o = 0x00, valid_o = 0, busy_o = 0, frame_err_o = 0 (and parity_err_o = 0 when present).
REQ-022 A frame in progress at reset SHALL be discarded; after release, reception resumes only at the next falling edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: frame SHALL carry an even-parity bit between data bit 7 and stop, sampled one CLKS_PER_BIT after data bit 7 (stop sample moves to k = 10); port parity_err_o output 1 SHALL exist.
REQ-024 With UART_RX_PARITY_EN: parity mismatch with good stop -> parity_err_o one-cycle pulse, no valid_o, byte_o unchanged; bad stop -> frame_err_o only.
REQ-025 Without UART_RX_PARITY_EN: 8N1 framing, no parity_err_o port, no parity logic.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum uart_rx_state_e (2-bit) and constant UART_CLKS_PER_BIT = 10416 used as the parameter default.
REQ-027 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer plus previous-value flop, outputting rx_s and a one-cycle fall_o pulse.

Verification (CLKS_PER_BIT = 16 unless stated)
REQ-028 Send 0xA5 8N1 -> valid_o one pulse, byte_o = 0xA5, one cycle after stop sample (edge + 152 cycles plus sync delay); busy_o high throughout frame.
REQ-029 rx_i low for 4 cycles then high -> no valid_o, no frame_err_o, busy_o falls after START rejection.
REQ-030 Send 0x3C with stop bit low -> frame_err_o one pulse, valid_o 0, byte_o keeps prior value; line then held low -> no new frame until a rising then falling edge.
REQ-031 Send 0x00 then 0xFF with zero idle gap -> two valid_o pulses, byte_o 0x00 then 0xFF.
REQ-032 Assert reset_i during data bit 4 of 0x5A -> all outputs 0 immediately; following 0x81 received correctly.
REQ-033 UART_RX_PARITY_EN: 0x07 with parity 1 -> valid_o, byte_o = 0x07; with parity 0 -> parity_err_o pulse, no valid_o.
